apb_slave_regfile: RTL
======================

// Module: apb_slave_regfile
// PURPOSE
//  APB (no PREADY/PSLVERR) completer: the slave-side consumer of apb_if signals driven through master_cb.
//  Holds NUM_REGS RW words plus one status word; drives prdata one cycle ahead of the access phase.
//  Tracks bus phase with an FSM, counts completed transfers and flags protocol violations.
//  Serves as DUT/slave BFM for the APB driver and monitor.
// PARAMETERS
//  ADDR_WIDTH  32            paddr width
//  DATA_WIDTH  32            pwdata/prdata width (>=32)
//  NUM_REGS    16            RW data registers (1..256)
//  BASE_ADDR   32'h0000_0000 byte address of register 0; word-aligned
// PORTS
//  pclk       in   1           clock, all logic on posedge
//  preset     in   1           reset, synchronous, active-high
//  paddr      in   ADDR_WIDTH  byte address; paddr[1:0] ignored
//  psel       in   1           select
//  penable    in   1           access phase
//  pwrite     in   1           1=write, 0=read
//  pwdata     in   DATA_WIDTH  write data
//  prdata     out  DATA_WIDTH  read data, registered
//  prot_err   out  1           1-cycle pulse on a protocol violation
// BEHAVIOUR
//  Reset (preset=1 at posedge): regs, prdata, counters = 0; prot_err = 0; FSM = IDLE. Mid-transfer reset aborts it silently.
//  Decode: off = paddr - BASE_ADDR; idx = off>>2. idx<NUM_REGS -> data reg; idx==NUM_REGS -> STATUS; else unmapped.
//  STATUS (RO data) = {err_cnt[15:0], xfer_cnt[15:0]}, zero-extended to DATA_WIDTH. Any write to STATUS clears both counters.
//  FSM (phase sampled at posedge):
//   IDLE  : psel&!penable -> SETUP, latch paddr/pwrite/pwdata; psel&penable -> IDLE + error.
//   SETUP : psel&penable -> ACCESS, commit if control matches latch; !psel -> IDLE + error;
//           psel&!penable -> SETUP + error, re-latch.
//   ACCESS: psel&!penable -> SETUP (back-to-back); !psel -> IDLE; psel&penable -> ACCESS + error.
//  Stability: paddr/pwrite/pwdata differing between SETUP and ACCESS -> error; transfer dropped.
//  Commit (SETUP->ACCESS, stable): write data reg at that edge; xfer_cnt+1 (wraps 0xFFFF->0).
//  Read: at the edge entering SETUP with pwrite=0, prdata <= decoded value; holds until next read setup
//        (write setups leave prdata unchanged). Master samples it at the ACCESS->next edge. Zero wait states.
//  Unmapped: reads load prdata=0; writes dropped; transfer still counts; not an error.
//  Error: prot_err=1 for the cycle after the offending edge; err_cnt+1, saturates at 0xFFFF.
//  Same-edge STATUS clear and count/error: clear wins; both counters = 0 (the clearing write is not counted).
// CONFIGURATION
//  APB_SLV_PROT_CHECK_EN defined: FSM errors, stability check, err_cnt and prot_err as above.
//  Not defined: no checking; every psel&penable edge whose previous edge had psel&!penable commits using
//   current-cycle paddr/pwdata; no stability check; penable held high commits nothing further;
//   prot_err tied 0; err_cnt reads 0; xfer_cnt unchanged.
// TESTING
//  1 Reset: preset=1 for 2 clks, then read addr 0x0 and STATUS(0x40) -> prdata=0, prot_err=0.
//  2 Write 0xA5A5_0001 to 0x8, read 0x8 -> 0xA5A5_0001 in ACCESS; STATUS=0x0000_0002.
//  3 Back-to-back: write 0x4, read 0x4 with no idle cycle -> read data = written data; xfer_cnt+2.
//  4 [_EN] penable without setup, then paddr 0x8->0xC changed in ACCESS -> two prot_err pulses,
//    err_cnt=2, reg 0x8 and 0xC unchanged.
//  5 Write to unmapped 0x80, read it -> prdata=0, no prot_err, xfer_cnt+2; write STATUS -> reads 0x0.
//  6 preset asserted during a write ACCESS edge -> write not committed; all regs read 0.

Source files
------------

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regfile
//  Brief    : APB completer with NUM_REGS RW words plus a STATUS word holding
//             transfer/error counters. Protocol checking is built in only when
//             APB_SLV_PROT_CHECK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  prot_err
);

    localparam int         c_IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SETUP  = 2'd1;
    localparam logic [1:0] c_S_ACCESS = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [15:0]           r_xfer_cnt;
    logic [15:0]           r_err_cnt;
    logic                  r_prot_err;
    logic [DATA_WIDTH-1:0] r_prdata;

    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [c_IDX_W-1:0]    w_ridx;
    logic                  w_is_reg;
    logic                  w_is_status;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_stable;
    logic                  w_commit;
    logic                  w_viol;
    logic                  w_err;
    logic                  w_clear;

    assign w_off       = paddr - BASE_ADDR;
    assign w_idx       = w_off >> 2;
    assign w_ridx      = w_idx[c_IDX_W-1:0];
    assign w_is_reg    = w_idx <  ADDR_WIDTH'(NUM_REGS);
    assign w_is_status = w_idx == ADDR_WIDTH'(NUM_REGS);
    assign w_setup     = psel & ~penable;
    assign w_access    = psel &  penable;

`ifdef APB_SLV_PROT_CHECK_EN
    localparam logic c_CHECK = 1'b1;

    logic [ADDR_WIDTH-1:0] r_lat_addr;
    logic                  r_lat_write;
    logic [DATA_WIDTH-1:0] r_lat_wdata;

    assign w_stable = (paddr == r_lat_addr) && (pwrite == r_lat_write) &&
                      (pwdata == r_lat_wdata);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_lat_addr  <= '0;
            r_lat_write <= 1'b0;
            r_lat_wdata <= '0;
        end else if (w_setup) begin
            r_lat_addr  <= paddr;
            r_lat_write <= pwrite;
            r_lat_wdata <= pwdata;
        end
    end
`else
    localparam logic c_CHECK = 1'b0;
    // Without checking, the access phase commits whatever is on the bus now.
    assign w_stable = 1'b1;
`endif

    always_comb begin
        w_next   = c_S_IDLE;
        w_commit = 1'b0;
        w_viol   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_setup) w_next = c_S_SETUP;
                else if (w_access) w_viol = 1'b1;
            end
            c_S_SETUP: begin
                if (w_access) begin
                    w_next   = c_S_ACCESS;
                    w_commit = w_stable;
                    w_viol   = ~w_stable;
                end else if (w_setup) begin
                    w_next = c_S_SETUP;
                    w_viol = 1'b1;
                end else begin
                    w_viol = 1'b1;
                end
            end
            c_S_ACCESS: begin
                if (w_setup) w_next = c_S_SETUP;
                else if (w_access) begin
                    w_next = c_S_ACCESS;
                    w_viol = 1'b1;
                end
            end
            default: w_next = c_S_IDLE;
        endcase
    end

    assign w_err   = c_CHECK & w_viol;
    assign w_clear = w_commit & pwrite & w_is_status;

    always_comb begin
        w_rd_val = '0;
        if (w_is_reg) w_rd_val = r_regs[w_ridx];
        else if (w_is_status) w_rd_val = DATA_WIDTH'({r_err_cnt, r_xfer_cnt});
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= c_S_IDLE;
            r_prdata   <= '0;
            r_xfer_cnt <= '0;
            r_err_cnt  <= '0;
            r_prot_err <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_prot_err <= w_err;
            // Read data is captured in the setup phase so it is ready for ACCESS.
            if (w_setup && !pwrite) r_prdata <= w_rd_val;
            if (w_clear) begin
                r_xfer_cnt <= '0;
                r_err_cnt  <= '0;
            end else begin
                if (w_commit) r_xfer_cnt <= r_xfer_cnt + 16'd1;
                if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit && pwrite && w_is_reg) begin
            r_regs[w_ridx] <= pwdata;
        end
    end

    assign prdata   = r_prdata;
    assign prot_err = r_prot_err;

endmodule
`default_nettype wire
